// File: rtl/if_id_ex_pipe.sv
// Non-pipelined RV32I fetch/decode/execute front end: one instruction in flight,
// with a valid/data register per stage and valid&ready hand-offs between stages.
module if_id_ex_pipe #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     imem_addr,
    input  logic [WIDTH-1:0]     imem_rdata,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [WIDTH-1:0]     rs1_data,
    input  logic [WIDTH-1:0]     rs2_data,
    output logic                 exu_valid,
    output logic [3*WIDTH+12:0]  exu_data,
    input  logic                 lsu_ready,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     inst
);

    localparam logic [WIDTH-1:0] RESET_PC   = 32'h8000_0000;
    localparam logic [6:0]       OPC_LUI    = 7'b0110111;
    localparam logic [6:0]       OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]       OPC_JAL    = 7'b1101111;
    localparam logic [6:0]       OPC_JALR   = 7'b1100111;
    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]       OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]       OPC_STORE  = 7'b0100011;
    localparam logic [6:0]       OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]       OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_wen;
        logic       mem_wen;
        logic       mem_ren;
        logic [1:0] mem_size;
        logic       mem_unsigned;
        logic [1:0] wb_sel;
        logic       alu_imm;
        logic       alu_alt;
        logic [2:0] funct3;
        logic       is_lui;
        logic       is_auipc;
        logic       is_jal;
        logic       is_jalr;
        logic       is_branch;
        logic       is_mem;
    } ctrl_t;

    function automatic logic [WIDTH-1:0] imm_i(input logic [WIDTH-1:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [WIDTH-1:0] imm_s(input logic [WIDTH-1:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [WIDTH-1:0] imm_b(input logic [WIDTH-1:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] imm_u(input logic [WIDTH-1:0] i);
        return {i[31:12], 12'h000};
    endfunction

    function automatic logic [WIDTH-1:0] imm_j(input logic [WIDTH-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    logic [WIDTH-1:0]    pc_q, pc_d;
    logic                boot_q, boot_d;
    logic                if_valid_q, if_valid_d;
    logic [WIDTH-1:0]    if_inst_q, if_inst_d, if_pc_q, if_pc_d;
    logic                id_valid_q, id_valid_d;
    logic [WIDTH-1:0]    id_pc_q, id_pc_d, id_rs1_q, id_rs1_d, id_rs2_q, id_rs2_d;
    logic [WIDTH-1:0]    id_imm_q, id_imm_d;
    ctrl_t               id_ctrl_q, id_ctrl_d;
    logic                ex_valid_q, ex_valid_d;
    logic [3*WIDTH+12:0] ex_data_q, ex_data_d;
    logic [WIDTH-1:0]    ex_npc_q, ex_npc_d;

    logic                fetch_s, if_hs_s, id_hs_s, ex_hs_s;
    ctrl_t               dec_s;
    logic [WIDTH-1:0]    dec_imm_s;
    logic [WIDTH-1:0]    op_b_s, agen_s, sra_s, alu_op_s, alu_s, npc_s;
    logic [4:0]          shamt_s;
    logic                taken_s;

    // A start pulse is only honoured when no stage holds an instruction.
    assign fetch_s = ~(if_valid_q | id_valid_q | ex_valid_q) & (boot_q | start);
    assign if_hs_s = if_valid_q & ~id_valid_q;
    assign id_hs_s = id_valid_q & ~ex_valid_q;
    assign ex_hs_s = ex_valid_q & lsu_ready;

    // Decode the IF-stage instruction into immediate and control fields.
    always_comb begin
        dec_s        = '0;
        dec_imm_s    = '0;
        dec_s.funct3 = if_inst_q[14:12];
        case (if_inst_q[6:0])
            OPC_LUI: begin
                dec_imm_s = imm_u(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.is_lui = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm_s = imm_u(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.is_auipc = 1'b1;
            end
            OPC_JAL: begin
                dec_imm_s = imm_j(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.wb_sel = 2'd2;
                dec_s.is_jal = 1'b1;
            end
            OPC_JALR: begin
                dec_imm_s = imm_i(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.wb_sel = 2'd2;
                dec_s.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm_s = imm_b(if_inst_q);
                dec_s.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm_s = imm_i(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.mem_ren = 1'b1;
                dec_s.mem_size = if_inst_q[13:12];
                dec_s.mem_unsigned = if_inst_q[14];
                dec_s.wb_sel = 2'd1;
                dec_s.is_mem = 1'b1;
            end
            OPC_STORE: begin
                dec_imm_s = imm_s(if_inst_q);
                dec_s.mem_wen = 1'b1;
                dec_s.mem_size = if_inst_q[13:12];
                dec_s.is_mem = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm_s = imm_i(if_inst_q);
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.alu_imm = 1'b1;
                dec_s.alu_alt = (if_inst_q[14:12] == 3'b101) & if_inst_q[30];
            end
            OPC_OP: begin
                dec_s.rd = if_inst_q[11:7];
                dec_s.reg_wen = 1'b1;
                dec_s.alu_alt = ((if_inst_q[14:12] == 3'b000) | (if_inst_q[14:12] == 3'b101)) & if_inst_q[30];
            end
            default: dec_imm_s = '0;
        endcase
    end

    // Execute: ALU, branch resolution and next-pc selection.
    always_comb begin
        op_b_s  = id_ctrl_q.alu_imm ? id_imm_q : id_rs2_q;
        shamt_s = op_b_s[4:0];
        agen_s  = id_rs1_q + id_imm_q;
        sra_s   = $signed(id_rs1_q) >>> shamt_s;
        case (id_ctrl_q.funct3)
            3'b000:  alu_op_s = id_ctrl_q.alu_alt ? (id_rs1_q - op_b_s) : (id_rs1_q + op_b_s);
            3'b001:  alu_op_s = id_rs1_q << shamt_s;
            3'b010:  alu_op_s = {{(WIDTH-1){1'b0}}, $signed(id_rs1_q) < $signed(op_b_s)};
            3'b011:  alu_op_s = {{(WIDTH-1){1'b0}}, id_rs1_q < op_b_s};
            3'b100:  alu_op_s = id_rs1_q ^ op_b_s;
            3'b101:  alu_op_s = id_ctrl_q.alu_alt ? sra_s : (id_rs1_q >> shamt_s);
            3'b110:  alu_op_s = id_rs1_q | op_b_s;
            3'b111:  alu_op_s = id_rs1_q & op_b_s;
            default: alu_op_s = '0;
        endcase
        case (id_ctrl_q.funct3)
            3'b000:  taken_s = (id_rs1_q == id_rs2_q);
            3'b001:  taken_s = (id_rs1_q != id_rs2_q);
            3'b100:  taken_s = ($signed(id_rs1_q) < $signed(id_rs2_q));
            3'b101:  taken_s = ($signed(id_rs1_q) >= $signed(id_rs2_q));
            3'b110:  taken_s = (id_rs1_q < id_rs2_q);
            3'b111:  taken_s = (id_rs1_q >= id_rs2_q);
            default: taken_s = 1'b0;
        endcase
        if (id_ctrl_q.is_lui) begin
            alu_s = id_imm_q;
        end else if (id_ctrl_q.is_auipc | id_ctrl_q.is_jal) begin
            alu_s = id_pc_q + id_imm_q;
        end else if (id_ctrl_q.is_jalr | id_ctrl_q.is_mem) begin
            alu_s = agen_s;
        end else begin
            alu_s = alu_op_s;
        end
        if (id_ctrl_q.is_jal | (id_ctrl_q.is_branch & taken_s)) begin
            npc_s = id_pc_q + id_imm_q;
        end else if (id_ctrl_q.is_jalr) begin
            npc_s = {agen_s[WIDTH-1:1], 1'b0};
        end else begin
            npc_s = id_pc_q + 32'd4;
        end
    end

    // Next-state for every stage register; each stage fills on its input handshake.
    always_comb begin
        pc_d       = pc_q;
        boot_d     = boot_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_rs1_d   = id_rs1_q;
        id_rs2_d   = id_rs2_q;
        id_imm_d   = id_imm_q;
        id_ctrl_d  = id_ctrl_q;
        ex_valid_d = ex_valid_q;
        ex_data_d  = ex_data_q;
        ex_npc_d   = ex_npc_q;
        if (fetch_s) begin
            boot_d     = 1'b0;
            if_valid_d = 1'b1;
            if_inst_d  = imem_rdata;
            if_pc_d    = pc_q;
        end else if (if_hs_s) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end
        if (if_hs_s) begin
            id_valid_d = 1'b1;
            id_pc_d    = if_pc_q;
            id_rs1_d   = rs1_data;
            id_rs2_d   = rs2_data;
            id_imm_d   = dec_imm_s;
            id_ctrl_d  = dec_s;
        end else if (id_hs_s) begin
            id_valid_d = 1'b0;
        end else begin
            id_valid_d = id_valid_q;
        end
        if (id_hs_s) begin
            ex_valid_d = 1'b1;
            ex_npc_d   = npc_s;
            ex_data_d  = {alu_s, id_rs2_q, id_pc_q + 32'd4, id_ctrl_q.rd, id_ctrl_q.reg_wen,
                          id_ctrl_q.mem_wen, id_ctrl_q.mem_ren, id_ctrl_q.mem_size,
                          id_ctrl_q.mem_unsigned, id_ctrl_q.wb_sel};
        end else if (ex_hs_s) begin
            ex_valid_d = 1'b0;
            pc_d       = ex_npc_q;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            boot_q     <= 1'b1;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_rs1_q   <= '0;
            id_rs2_q   <= '0;
            id_imm_q   <= '0;
            id_ctrl_q  <= '0;
            ex_valid_q <= 1'b0;
            ex_data_q  <= '0;
            ex_npc_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            boot_q     <= boot_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_rs1_q   <= id_rs1_d;
            id_rs2_q   <= id_rs2_d;
            id_imm_q   <= id_imm_d;
            id_ctrl_q  <= id_ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_data_q  <= ex_data_d;
            ex_npc_q   <= ex_npc_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = if_inst_q;
    assign rs1_addr  = if_inst_q[19:15];
    assign rs2_addr  = if_inst_q[24:20];
    assign exu_valid = ex_valid_q;
    assign exu_data  = ex_data_q;

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Bench for if_id_ex_pipe: directed scenarios plus random RV32I instructions
// checked against an instruction-level reference model.
module tb_if_id_ex_pipe;

    logic         clk = 1'b0;
    logic         rst, start, lsu_ready, exu_valid;
    logic [31:0]  imem_addr, imem_rdata, rs1_data, rs2_data, pc, inst;
    logic [4:0]   rs1_addr, rs2_addr;
    logic [108:0] exu_data;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  m_pc;
    logic [108:0] got_data;
    logic [31:0]  got_pc;

    always #5 clk = ~clk;

    if_id_ex_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exu_valid(exu_valid), .exu_data(exu_data), .lsu_ready(lsu_ready), .pc(pc), .inst(inst)
    );

    task automatic chk(input string tag, input logic [108:0] obs, input logic [108:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: expected result fields, don't-care mask and next pc.
    function automatic void model(input logic [31:0] in, input logic [31:0] cpc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [108:0] e, output logic [108:0] m,
                                  output logic [31:0] npc);
        logic [31:0] ii, si, bi, ui, ji, res, opb;
        logic [4:0]  rd;
        logic        wen, mw, mr, uns, alt, tk;
        logic [1:0]  sz, wbs;
        logic        c_res, c_sd, c_rd, c_sz, c_uns, c_wb;
        logic [2:0]  f3;
        int          sh;
        ii = 32'($signed(in[31:20]));
        si = 32'($signed({in[31:25], in[11:7]}));
        bi = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
        ji = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
        ui = in & 32'hFFFF_F000;
        f3 = in[14:12];
        npc = cpc + 32'd4;
        res = 32'd0; rd = 5'd0; wen = 1'b0; mw = 1'b0; mr = 1'b0;
        sz = 2'd0; uns = 1'b0; wbs = 2'd0; tk = 1'b0;
        c_res = 1'b0; c_sd = 1'b0; c_rd = 1'b0; c_sz = 1'b0; c_uns = 1'b0; c_wb = 1'b0;
        case (in[6:0])
            7'b0110111, 7'b0010111: begin
                res = (in[5] ? 32'd0 : cpc) + ui;
                rd = in[11:7]; wen = 1'b1; c_res = 1'b1; c_rd = 1'b1; c_wb = 1'b1;
            end
            7'b1101111: begin
                rd = in[11:7]; wen = 1'b1; wbs = 2'd2; c_rd = 1'b1; c_wb = 1'b1;
                npc = cpc + ji;
            end
            7'b1100111: begin
                res = a + ii; rd = in[11:7]; wen = 1'b1; wbs = 2'd2;
                c_res = 1'b1; c_rd = 1'b1; c_wb = 1'b1;
                npc = (a + ii) & 32'hFFFF_FFFE;
            end
            7'b1100011: begin
                c_rd = 1'b1;
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) npc = cpc + bi;
            end
            7'b0000011: begin
                res = a + ii; rd = in[11:7]; wen = 1'b1; mr = 1'b1;
                sz = f3[1:0]; uns = f3[2]; wbs = 2'd1;
                c_res = 1'b1; c_rd = 1'b1; c_sz = 1'b1; c_uns = 1'b1; c_wb = 1'b1;
            end
            7'b0100011: begin
                res = a + si; mw = 1'b1; sz = f3[1:0];
                c_res = 1'b1; c_sd = 1'b1; c_rd = 1'b1; c_sz = 1'b1;
            end
            7'b0010011, 7'b0110011: begin
                opb = in[5] ? b : ii;
                sh = int'(opb % 32'd32);
                alt = in[30] & ((f3 == 3'd5) | (in[5] & (f3 == 3'd0)));
                case (f3)
                    3'd0: res = alt ? a - opb : a + opb;
                    3'd1: res = a << sh;
                    3'd2: res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < opb) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ opb;
                    3'd5: begin
                        if (alt) res = $signed(a) >>> sh;
                        else res = a >> sh;
                    end
                    3'd6: res = a | opb;
                    default: res = a & opb;
                endcase
                rd = in[11:7]; wen = 1'b1; c_res = 1'b1; c_rd = 1'b1; c_wb = 1'b1;
            end
            default: res = 32'd0;
        endcase
        e = {res, b, cpc + 32'd4, rd, wen, mw, mr, sz, uns, wbs};
        m = {{32{c_res}}, {32{c_sd}}, {32{1'b1}}, {5{c_rd}}, 3'b111, {2{c_sz}}, c_uns, {2{c_wb}}};
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r, s;
        logic [2:0]  f3;
        logic [4:0]  rd, r1, r2;
        logic [11:0] i12;
        logic [6:0]  f7, opc;
        r = $urandom; s = $urandom;
        rd = s[4:0]; r1 = s[9:5]; r2 = s[14:10]; f3 = s[17:15];
        case (s[21:18] % 4'd10)
            4'd0: return {r[31:12], rd, 7'b0110111};
            4'd1: return {r[31:12], rd, 7'b0010111};
            4'd2: return {r[31:12], rd, 7'b1101111};
            4'd3: return {r[31:20], r1, 3'b000, rd, 7'b1100111};
            4'd4: begin
                if (f3[2:1] == 2'b01) f3[2] = 1'b1;
                return {r[31:25], r2, r1, f3, r[11:7], 7'b1100011};
            end
            4'd5: begin
                f3 = f3 % 3'd5;
                if (f3 > 3'd2) f3 = f3 + 3'd1;
                return {r[31:20], r1, f3, rd, 7'b0000011};
            end
            4'd6: return {r[31:25], r2, r1, f3 % 3'd3, r[11:7], 7'b0100011};
            4'd7: begin
                if (f3 == 3'd1) i12 = {7'd0, r[24:20]};
                else if (f3 == 3'd5) i12 = {1'b0, r[30], 5'd0, r[24:20]};
                else i12 = r[31:20];
                return {i12, r1, f3, rd, 7'b0010011};
            end
            4'd8: begin
                f7 = ((f3 == 3'd0) || (f3 == 3'd5)) ? {1'b0, r[30], 5'd0} : 7'd0;
                return {f7, r2, r1, f3, rd, 7'b0110011};
            end
            default: begin
                case (r[1:0])
                    2'd0: opc = 7'b0001111;
                    2'd1: opc = 7'b1110011;
                    2'd2: opc = 7'b0000000;
                    default: opc = 7'b1111111;
                endcase
                return {r[31:7], opc};
            end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; lsu_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", exu_valid, 0);
        chk("rst_data", exu_data, 0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_imem_addr", imem_addr, 32'h8000_0000);
        m_pc = 32'h8000_0000;
    endtask

    // One instruction end to end: fetch (boot or start), latency, result, stall, retire.
    task automatic run_instr(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                             input int delay, input bit boot);
        logic [108:0] e, m;
        logic [31:0]  npc;
        int           n;
        bit           seen;
        model(in, m_pc, a, b, e, m, npc);
        @(negedge clk);
        imem_rdata = in; rs1_data = a; rs2_data = b; lsu_ready = 1'b0;
        if (boot) rst = 1'b1;
        else start = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            seen = exu_valid;
        end
        chk("latency", n, 3);
        chk("exu_data", exu_data & m, e & m);
        chk("pc_before_retire", pc, m_pc);
        chk("rs_addr", {rs1_addr, rs2_addr}, {in[19:15], in[24:20]});
        chk("inst", inst, in);
        got_data = exu_data;
        for (int d = 0; d < delay; d++) begin
            imem_rdata = $urandom;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", exu_valid, 1);
            chk("stall_data", exu_data, got_data);
            chk("stall_pc", pc, m_pc);
        end
        lsu_ready = 1'b1;
        @(negedge clk);
        lsu_ready = 1'b0;
        got_pc = pc;
        chk("next_pc", pc, npc);
        chk("retire_valid", exu_valid, 0);
        m_pc = npc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_valid", exu_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b0; start = 1'b0; lsu_ready = 1'b0;
        imem_rdata = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        m_pc = 32'h8000_0000;

        do_reset();
        run_instr(32'h0050_0093, 32'd0, 32'd0, 0, 1'b1);
        chk("addi_alu", got_data[108:77], 32'd5);
        chk("addi_rd", got_data[12:8], 5'd1);
        chk("addi_wen", got_data[7], 1'b1);
        chk("addi_wbsel", got_data[1:0], 2'd0);
        chk("addi_pc", got_pc, 32'h8000_0004);

        do_reset();
        run_instr(32'h0020_8463, 32'd7, 32'd7, 0, 1'b1);
        chk("beq_taken_pc", got_pc, 32'h8000_0008);
        chk("beq_wen", got_data[7], 1'b0);
        do_reset();
        run_instr(32'h0020_8463, 32'd7, 32'd8, 0, 1'b1);
        chk("beq_not_taken_pc", got_pc, 32'h8000_0004);

        do_reset();
        run_instr(32'h0042_80E7, 32'h8000_1003, 32'd0, 1, 1'b1);
        chk("jalr_pc", got_pc, 32'h8000_1006);
        chk("jalr_alu", got_data[108:77], 32'h8000_1007);
        chk("jalr_pc4", got_data[44:13], 32'h8000_0004);
        chk("jalr_wbsel", got_data[1:0], 2'd2);

        do_reset();
        run_instr(32'hFE62_AE23, 32'h0000_0100, 32'hDEAD_BEEF, 2, 1'b1);
        chk("sw_alu", got_data[108:77], 32'h0000_00FC);
        chk("sw_data", got_data[76:45], 32'hDEAD_BEEF);
        chk("sw_mwen", got_data[6], 1'b1);
        chk("sw_size", got_data[4:3], 2'd2);

        do_reset();
        run_instr(32'h0050_0093, 32'd0, 32'd0, 5, 1'b1);
        chk("stall5_pc", got_pc, 32'h8000_0004);

        // Reset while the instruction sits in ID: discarded, no pc update.
        @(negedge clk);
        imem_rdata = 32'h0050_0093; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", exu_valid, 0);
        chk("midrst_pc", pc, 32'h8000_0000);
        chk("midrst_data", exu_data, 0);
        m_pc = 32'h8000_0000;
        run_instr(32'h0090_0113, 32'd0, 32'd0, 0, 1'b1);
        chk("midrst_refetch_pc4", got_data[44:13], 32'h8000_0004);

        // Wrap-around of pc and pc_plus4 at the top of the address space.
        run_instr(32'h00C0_8067, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
        chk("wrap_jalr_pc", got_pc, 32'hFFFF_FFFC);
        run_instr(32'h0050_0093, 32'd0, 32'd0, 0, 1'b0);
        chk("wrap_pc", got_pc, 32'h0000_0000);
        chk("wrap_pc4", got_data[44:13], 32'h0000_0000);

        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            run_instr(gen_inst(), a, b, $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_ex_pipe.md
IF_ID_EX_PIPE -- requirements
Module: if_id_ex_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath/register width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: writeback-complete pulse that permits the next fetch.
REQ-005 SHALL have port imem_addr, output, 32 bits: fetch address, equal to pc.
REQ-006 SHALL have port imem_rdata, input, 32 bits: instruction at imem_addr, valid in the same cycle.
REQ-007 SHALL have ports rs1_addr and rs2_addr, output, 5 bits each: register-file read addresses, inst[19:15] and inst[24:20] of the IF-stage instruction.
REQ-008 SHALL have ports rs1_data and rs2_data, input, 32 bits each: combinational register-file read data.
REQ-009 SHALL have port exu_valid, output, 1 bit: exu_data holds a valid result.
REQ-010 SHALL have port exu_data, output, 109 bits: execute result, packed MSB to LSB as alu_res[31:0], store_data[31:0], pc_plus4[31:0], rd[4:0], reg_wen, mem_wen, mem_ren, mem_size[1:0] (0=byte, 1=half, 2=word), mem_unsigned, wb_sel[1:0] (0=ALU, 1=memory, 2=pc_plus4).
REQ-011 SHALL have port lsu_ready, input, 1 bit: downstream accepts exu_data.
REQ-012 SHALL have port pc, output, 32 bits: current program counter.
REQ-013 SHALL have port inst, output, 32 bits: instruction held in the IF register.

Function
REQ-014 SHALL run non-pipelined: one instruction in flight; IF, ID and EX each hold a valid/data register.
REQ-015 SHALL transfer between stages only when valid and ready are both high on the same clock edge (valid&ready); a valid SHALL stay high, with data stable, until accepted.
REQ-016 SHALL latch {imem_rdata, pc} into IF on the first cycle after reset and on each cycle where start=1; ifu_valid SHALL rise one cycle later.
REQ-017 SHALL have the ID stage accept when empty, decode, and register {pc, inst, rs1_data, rs2_data, imm, control}; idu_valid SHALL rise one cycle after the IF handshake.
REQ-018 SHALL decode the RV32I subset: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, and OP (including SUB/SRA).
REQ-019 SHALL decode any other opcode as a NOP: reg_wen=mem_wen=mem_ren=0, and pc advances by 4.
REQ-020 SHALL sign-extend immediates per I/S/B/U/J format; shift amounts SHALL use bits [4:0]; SLT/SLTU SHALL yield 0 or 1.
REQ-021 SHALL have the EX stage compute alu_res and register exu_data; exu_valid SHALL rise one cycle after the ID handshake.
REQ-022 SHALL compute alu_res as: rs1+imm for loads and stores, imm for LUI, pc+imm for AUIPC.
REQ-023 SHALL set rd=0 and reg_wen=0 for branches and stores.
REQ-024 SHALL compute next pc as: pc+4 by default; pc+imm for JAL and taken branches; (rs1+imm)&~1 for JALR.
REQ-025 SHALL update the pc register only on the EX-to-LSU handshake (exu_valid & lsu_ready).
REQ-026 SHALL perform all address arithmetic modulo 2^32 (wrap-around).
REQ-027 SHALL hold exu_valid and exu_data unchanged while lsu_ready=0.
REQ-028 SHALL ignore a start pulse arriving while an instruction is in flight.

Reset
REQ-029 SHALL, when rst=0 at a clock edge, set pc=0x80000000, clear ifu_valid, idu_valid and exu_valid, and zero exu_data.
REQ-030 SHALL, when reset is asserted mid-instruction, discard the in-flight instruction with no pc update; the first fetch after release SHALL be from 0x80000000.

Verification
REQ-031 SHALL pass: after reset, imem_rdata=0x00500093 (addi x1,x0,5) -> exu_valid at cycle 3 with alu_res=5, rd=1, reg_wen=1, wb_sel=0; then with lsu_ready=1, pc=0x80000004.
REQ-032 SHALL pass: beq x1,x2,+8 with rs1_data=rs2_data=7 -> pc=0x80000008 and reg_wen=0; with rs2_data=8 -> pc=0x80000004.
REQ-033 SHALL pass: jalr x1,4(x5) with rs1_data=0x80001003 -> pc=0x80001006, alu_res=0x80001007, pc_plus4=0x80000004, wb_sel=2.
REQ-034 SHALL pass: sw x6,-4(x5) with rs1_data=0x100, rs2_data=0xDEADBEEF -> alu_res=0xFC, store_data=0xDEADBEEF, mem_wen=1, mem_size=2.
REQ-035 SHALL pass: lsu_ready held at 0 for 5 cycles -> exu_valid and exu_data stable and pc unchanged; pc updates on the cycle lsu_ready rises.
REQ-036 SHALL pass: rst=0 while idu_valid=1 -> next cycle all valids are 0 and pc=0x80000000.
